// File: rtl/spi_slave_if.sv
// SPI pins and CPU-side bus of the SPI responder, grouped for port connection.
// The CPU read bus (dout) stays a plain port on the block so it can float.
interface spi_slave_if;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_di;
  logic       spi_do;
  logic       spi_do_oe;
  logic [7:0] din;
  logic       cargar_dato;
  logic       leer_dato;
  logic       leer_estado;
  logic       oe_n;
  logic       irq_n;

  modport slave (
    input  spi_clk, spi_cs_n, spi_di, din, cargar_dato, leer_dato, leer_estado,
    output spi_do, spi_do_oe, oe_n, irq_n
  );

  modport master (
    output spi_clk, spi_cs_n, spi_di, din, cargar_dato, leer_dato, leer_estado,
    input  spi_do, spi_do_oe, oe_n, irq_n
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder on the system clock: synchronised SCK/CS/DI, MSB first,
// one RX and one TX holding byte, status flags and irq_n for the CPU.
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus,
  output logic [7:0]  dout
);

  localparam int unsigned CNT_W = 3;

  logic [1:0]       sck_sync, cs_sync, di_sync;
  logic             sck_hist, cs_hist;
  logic [CNT_W-1:0] bitcnt;
  logic [7:0]       rx_shift, rx_buf, tx_shift, tx_buf;
  logic             rx_lleno, tx_vacio, overrun, underrun;
  logic             leer_dato_q, leer_estado_q;

  logic       cs_activo, cs_fall, cs_rise, sck_rise, sck_fall;
  logic       byte_done, reload, rd_dato_fin, rd_estado_fin;
  logic [7:0] rx_byte, status, rd_data;

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= 2'b00;
      cs_sync  <= 2'b11;
      di_sync  <= 2'b11;
      sck_hist <= 1'b0;
      cs_hist  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[0], bus.spi_clk};
      cs_sync  <= {cs_sync[0], bus.spi_cs_n};
      di_sync  <= {di_sync[0], bus.spi_di};
      sck_hist <= sck_sync[1];
      cs_hist  <= cs_sync[1];
    end
  end

  // CS rise takes precedence over a coincident SCK edge
  always_comb begin
    cs_activo     = ~cs_hist;
    cs_fall       = cs_hist & ~cs_sync[1];
    cs_rise       = ~cs_hist & cs_sync[1];
    sck_rise      = cs_activo & ~cs_rise & sck_sync[1] & ~sck_hist;
    sck_fall      = cs_activo & ~cs_rise & ~sck_sync[1] & sck_hist;
    byte_done     = sck_rise & (bitcnt == CNT_W'(7));
    reload        = cs_fall | byte_done;
    rx_byte       = {rx_shift[6:0], di_sync[1]};
    rd_dato_fin   = leer_dato_q & ~bus.leer_dato;
    rd_estado_fin = leer_estado_q & ~bus.leer_estado;
    status        = {3'b000, cs_activo, underrun, overrun, tx_vacio, rx_lleno};
    rd_data       = bus.leer_dato ? rx_buf : status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt        <= '0;
      rx_shift      <= 8'h00;
      rx_buf        <= 8'h00;
      tx_shift      <= IDLE_BYTE;
      tx_buf        <= 8'h00;
      rx_lleno      <= 1'b0;
      tx_vacio      <= 1'b1;
      overrun       <= 1'b0;
      underrun      <= 1'b0;
      leer_dato_q   <= 1'b0;
      leer_estado_q <= 1'b0;
    end else begin
      leer_dato_q   <= bus.leer_dato;
      leer_estado_q <= bus.leer_estado;

      if (cs_fall || cs_rise)
        bitcnt <= '0;
      else if (sck_rise)
        bitcnt <= bitcnt + CNT_W'(1);

      if (sck_rise)
        rx_shift <= rx_byte;

      // A full byte only lands in rx_buf when the CPU has drained the last one
      if (byte_done && !rx_lleno)
        rx_buf <= rx_byte;

      if (byte_done && !rx_lleno)
        rx_lleno <= 1'b1;
      else if (rd_dato_fin)
        rx_lleno <= 1'b0;

      if (byte_done && rx_lleno)
        overrun <= 1'b1;
      else if (rd_estado_fin)
        overrun <= 1'b0;

      if (reload && tx_vacio)
        underrun <= 1'b1;
      else if (rd_estado_fin)
        underrun <= 1'b0;

      // No shift on the fall that follows a byte boundary, so the reloaded MSB stays out
      if (reload)
        tx_shift <= tx_vacio ? IDLE_BYTE : tx_buf;
      else if (sck_fall && (bitcnt != '0))
        tx_shift <= {tx_shift[6:0], 1'b1};

      if (bus.cargar_dato)
        tx_buf <= bus.din;

      if (bus.cargar_dato)
        tx_vacio <= 1'b0;
      else if (reload && !tx_vacio)
        tx_vacio <= 1'b1;
    end
  end

  assign bus.spi_do    = tx_shift[7];
  assign bus.spi_do_oe = cs_activo;
  assign bus.irq_n     = ~rx_lleno;
  assign bus.oe_n      = ~(bus.leer_dato | bus.leer_estado);
  assign dout          = bus.oe_n ? 8'hzz : rd_data;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: plays the SPI master at clk/8 and the CPU, against a
// byte-level model of the holding registers and status flags.
module tb_spi_slave;

  localparam logic [7:0] IDLE = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  [7:0] dout;

  spi_slave_if bus();

  spi_slave #(.IDLE_BYTE(IDLE)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .dout (dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Byte-level model
  logic [7:0] m_rx_buf, m_tx_buf, m_next;
  logic       m_rx_lleno, m_tx_vacio, m_overrun, m_underrun, m_cs;
  bit         m_valid = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {3'b000, m_cs, m_underrun, m_overrun, m_tx_vacio, m_rx_lleno};
  endfunction

  // The byte the next transfer will carry, decided at CS fall or a byte boundary
  task automatic model_reload();
    if (!m_tx_vacio) begin
      m_next     = m_tx_buf;
      m_tx_vacio = 1'b1;
    end else begin
      m_next     = IDLE;
      m_underrun = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("oe_n", {7'd0, bus.oe_n}, {7'd0, ~(bus.leer_dato | bus.leer_estado)});
      if (m_valid) begin
        check("irq_n", {7'd0, bus.irq_n}, {7'd0, ~m_rx_lleno});
        check("spi_do_oe", {7'd0, bus.spi_do_oe}, {7'd0, m_cs});
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_valid         = 1'b0;
    rst             = 1'b1;
    bus.spi_clk     = 1'b0;
    bus.spi_cs_n    = 1'b1;
    bus.spi_di      = 1'b1;
    bus.din         = 8'h00;
    bus.cargar_dato = 1'b0;
    bus.leer_dato   = 1'b0;
    bus.leer_estado = 1'b0;
    clk_wait(3);
    rst        = 1'b0;
    m_rx_buf   = 8'h00;
    m_tx_buf   = 8'h00;
    m_next     = IDLE;
    m_rx_lleno = 1'b0;
    m_tx_vacio = 1'b1;
    m_overrun  = 1'b0;
    m_underrun = 1'b0;
    m_cs       = 1'b0;
    m_valid    = 1'b1;
  endtask

  task automatic cargar(input logic [7:0] b);
    bus.din         = b;
    bus.cargar_dato = 1'b1;
    clk_wait(1);
    bus.cargar_dato = 1'b0;
    m_tx_buf   = b;
    m_tx_vacio = 1'b0;
  endtask

  task automatic rd_data(output logic [7:0] d);
    bus.leer_dato = 1'b1;
    #1;
    d = dout;
    check("rx_data", dout, m_rx_buf);
    clk_wait(1);
    bus.leer_dato = 1'b0;
    clk_wait(1);
    m_rx_lleno = 1'b0;
  endtask

  task automatic rd_status(output logic [7:0] st);
    bus.leer_estado = 1'b1;
    #1;
    st = dout;
    check("status", dout, m_status());
    clk_wait(1);
    bus.leer_estado = 1'b0;
    clk_wait(1);
    m_overrun  = 1'b0;
    m_underrun = 1'b0;
  endtask

  task automatic cs_low();
    m_valid      = 1'b0;
    bus.spi_cs_n = 1'b0;
    model_reload();
    m_cs = 1'b1;
    clk_wait(4);
    m_valid = 1'b1;
  endtask

  task automatic cs_high();
    m_valid      = 1'b0;
    bus.spi_cs_n = 1'b1;
    clk_wait(5);
    m_cs    = 1'b0;
    m_valid = 1'b1;
  endtask

  // Sends nbits MSB-first; optionally pulses cargar_dato exactly when the 8th rise is acted on
  task automatic xfer(input logic [7:0] mosi, input int nbits, input bit bl,
                      input logic [7:0] bl_byte, output logic [7:0] got);
    logic [7:0] exp, mask;
    exp     = m_next;
    got     = 8'h00;
    mask    = 8'hFF;
    mask    = mask << (8 - nbits);
    m_valid = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.spi_di = mosi[i];
      clk_wait(4);
      got[i] = bus.spi_do;
      bus.spi_clk = 1'b1;
      if (i == 0 && bl) begin
        clk_wait(2);
        bus.din         = bl_byte;
        bus.cargar_dato = 1'b1;
        clk_wait(1);
        bus.cargar_dato = 1'b0;
        clk_wait(1);
      end else begin
        clk_wait(4);
      end
      bus.spi_clk = 1'b0;
    end
    check("miso", got & mask, exp & mask);
    if (nbits == 8) begin
      if (!m_rx_lleno) begin
        m_rx_buf   = mosi;
        m_rx_lleno = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
      model_reload();
      if (bl) begin
        m_tx_buf   = bl_byte;
        m_tx_vacio = 1'b0;
      end
    end
    clk_wait(4);
    m_valid = 1'b1;
  endtask

  logic [7:0] v;

  initial begin
    do_reset();
    // Reset state
    check("rst_spi_do", {7'd0, bus.spi_do}, 8'h01);
    check("rst_spi_do_oe", {7'd0, bus.spi_do_oe}, 8'h00);
    check("rst_irq_n", {7'd0, bus.irq_n}, 8'h01);
    rd_status(v);  check("rst_status", v, 8'h02);

    // Single byte exchange, then RX read clears irq
    cargar(8'hA5);
    cs_low();
    xfer(8'h3C, 8, 1'b0, 8'h00, v);  check("t2_miso", v, 8'hA5);
    check("t2_irq_n", {7'd0, bus.irq_n}, 8'h00);
    rd_status(v);  check("t2_status", v, 8'h1B);
    rd_data(v);    check("t2_rx", v, 8'h3C);
    check("t2_irq_after", {7'd0, bus.irq_n}, 8'h01);
    cs_high();

    // Back-to-back with one load: underrun, sticky until status read
    cargar(8'h5A);
    cs_low();
    xfer(8'h01, 8, 1'b0, 8'h00, v);  check("t3_miso0", v, 8'h5A);
    xfer(8'h02, 8, 1'b0, 8'h00, v);  check("t3_miso1", v, 8'hFF);
    cs_high();
    rd_status(v);  check("t3_status1", v, 8'h0F);
    rd_status(v);  check("t3_status2", v, 8'h03);
    rd_data(v);    check("t3_rx", v, 8'h01);

    // Overrun: second byte discarded
    cs_low();
    xfer(8'h11, 8, 1'b0, 8'h00, v);
    xfer(8'h22, 8, 1'b0, 8'h00, v);
    check("t4_irq_n", {7'd0, bus.irq_n}, 8'h00);
    cs_high();
    rd_status(v);  check("t4_status", v, 8'h0F);
    rd_data(v);    check("t4_rx", v, 8'h11);

    // Aborted partial byte, then a clean byte keeps alignment
    cs_low();
    xfer(8'hF0, 5, 1'b0, 8'h00, v);
    cs_high();
    rd_status(v);  check("t5_status", v, 8'h0A);
    cs_low();
    xfer(8'h81, 8, 1'b0, 8'h00, v);
    cs_high();
    rd_data(v);    check("t5_rx", v, 8'h81);
    rd_status(v);

    // CPU load coincident with the boundary reload while TX is empty
    cargar(8'h96);
    cs_low();
    xfer(8'h00, 8, 1'b1, 8'hC3, v);  check("t6_miso0", v, 8'h96);
    xfer(8'h00, 8, 1'b0, 8'h00, v);  check("t6_miso1", v, 8'hFF);
    xfer(8'h00, 8, 1'b0, 8'h00, v);  check("t6_miso2", v, 8'hC3);
    cs_high();
    rd_status(v);  check("t6_status", v, 8'h0F);
    rd_data(v);

    // Reset in the middle of a byte
    cs_low();
    xfer(8'hAA, 4, 1'b0, 8'h00, v);
    do_reset();
    rd_status(v);  check("t1_midrst_status", v, 8'h02);
    cs_low();
    xfer(8'h6D, 8, 1'b0, 8'h00, v);  check("t1_midrst_miso", v, 8'hFF);
    cs_high();
    rd_data(v);    check("t1_midrst_rx", v, 8'h6D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
